mxint_cast_fifo: RTL and testbench

- Buffered MXINT block re-formatter: accepts one MXINT block per handshake (BLOCK_SIZE signed mantissas sharing one signed exponent).
- Converts the block to a new mantissa/exponent width in a one-register cast stage, then queues it in a DEPTH-entry FIFO.
- Used on each input branch of MXINT stream operators (concat, add) to give precision alignment plus elasticity.

---
 rtl/mxint_cast_fifo.sv | 187 ++++++++++++++++++
 tb/tb_mxint_cast_fifo.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxint_cast_fifo.sv
// mxint_cast_fifo
//   Re-formats one MXINT block (BLOCK_SIZE signed mantissas sharing one signed
//   exponent) to a new mantissa/exponent width through a single cast register.
//   The result is then queued in a DEPTH-entry FIFO. Total buffering is DEPTH+1 blocks.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active low
//   mdata_in        input mantissas, IN_MAN_WIDTH each, BLOCK_SIZE entries
//   edata_in        input shared exponent
//   data_in_valid   input block valid
//   data_in_ready   block accepted when valid && ready
//   mdata_out       FIFO head mantissas (don't-care while data_out_valid is low)
//   edata_out       FIFO head exponent
//   data_out_valid  FIFO non-empty
//   data_out_ready  consumer pop request
//   count           FIFO occupancy (cast register not included)
module mxint_cast_fifo #(
  parameter int IN_MAN_WIDTH  = 8,
  parameter int IN_EXP_WIDTH  = 8,
  parameter int OUT_MAN_WIDTH = 8,
  parameter int OUT_EXP_WIDTH = 8,
  parameter int BLOCK_SIZE    = 4,
  parameter int DEPTH         = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [IN_MAN_WIDTH-1:0]    mdata_in [BLOCK_SIZE],
  input  logic signed [IN_EXP_WIDTH-1:0]    edata_in,
  input  logic                              data_in_valid,
  output logic                              data_in_ready,
  output logic signed [OUT_MAN_WIDTH-1:0]   mdata_out [BLOCK_SIZE],
  output logic signed [OUT_EXP_WIDTH-1:0]   edata_out,
  output logic                              data_out_valid,
  input  logic                              data_out_ready,
  output logic [$clog2(DEPTH+1)-1:0]        count
);

  localparam int MAN_SHIFT = OUT_MAN_WIDTH - IN_MAN_WIDTH;
  localparam int EW = ((IN_EXP_WIDTH > OUT_EXP_WIDTH) ? IN_EXP_WIDTH : OUT_EXP_WIDTH) + 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic signed [EW-1:0] E_DELTA = EW'(IN_MAN_WIDTH - OUT_MAN_WIDTH);
  localparam logic signed [EW-1:0] E_MAX_W = EW'((2 ** (OUT_EXP_WIDTH-1)) - 1);
  localparam logic signed [EW-1:0] E_MIN_W = EW'(-(2 ** (OUT_EXP_WIDTH-1)));
  localparam logic signed [OUT_EXP_WIDTH-1:0] E_MAX_O = {1'b0, {(OUT_EXP_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_EXP_WIDTH-1:0] E_MIN_O = {1'b1, {(OUT_EXP_WIDTH-1){1'b0}}};
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // ---------------------------------------------------------------- cast logic
  logic signed [OUT_MAN_WIDTH-1:0] man_cast [BLOCK_SIZE];
  logic signed [EW-1:0]            e_ext;
  logic signed [EW-1:0]            e_adj;
  logic signed [OUT_EXP_WIDTH-1:0] exp_cast;

  for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_man
    if (MAN_SHIFT > 0) begin : g_widen
      assign man_cast[gi] = {mdata_in[gi], {MAN_SHIFT{1'b0}}};
    end else if (MAN_SHIFT < 0) begin : g_narrow
      // Arithmetic shift right by |D| then truncation to OUT bits is exactly
      // the top OUT bits of the input: floor rounding for free.
      logic unused_lsbs;
      assign unused_lsbs  = ^mdata_in[gi][-MAN_SHIFT-1:0];
      assign man_cast[gi] = mdata_in[gi][IN_MAN_WIDTH-1:IN_MAN_WIDTH-OUT_MAN_WIDTH];
    end else begin : g_pass
      assign man_cast[gi] = mdata_in[gi];
    end
  end

  // Exponent moves opposite to the mantissa shift; two guard bits keep the
  // sum from wrapping before the clamp.
  assign e_ext = {{(EW-IN_EXP_WIDTH){edata_in[IN_EXP_WIDTH-1]}}, edata_in};
  assign e_adj = e_ext + E_DELTA;

  always_comb begin
    if (e_adj > E_MAX_W) begin
      exp_cast = E_MAX_O;
    end else if (e_adj < E_MIN_W) begin
      exp_cast = E_MIN_O;
    end else begin
      exp_cast = e_adj[OUT_EXP_WIDTH-1:0];
    end
  end

  // ------------------------------------------------------------ cast register
  logic signed [OUT_MAN_WIDTH-1:0] c_man_q [BLOCK_SIZE];
  logic signed [OUT_MAN_WIDTH-1:0] c_man_d [BLOCK_SIZE];
  logic signed [OUT_EXP_WIDTH-1:0] c_exp_q, c_exp_d;
  logic                            c_valid_q, c_valid_d;

  // ---------------------------------------------------------------------- FIFO
  logic signed [OUT_MAN_WIDTH-1:0] man_mem_q [DEPTH][BLOCK_SIZE];
  logic signed [OUT_MAN_WIDTH-1:0] man_mem_d [DEPTH][BLOCK_SIZE];
  logic signed [OUT_EXP_WIDTH-1:0] exp_mem_q [DEPTH];
  logic signed [OUT_EXP_WIDTH-1:0] exp_mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic fifo_full;
  logic accept;
  logic push;
  logic pop;

  // Full is judged on registered count only: a pop in the same cycle does not
  // free a slot for the cast register until the next cycle.
  assign fifo_full      = (count_q == CNT_FULL);
  assign push           = c_valid_q && !fifo_full;
  assign data_in_ready  = !c_valid_q || !fifo_full;
  assign accept         = data_in_valid && data_in_ready;
  assign data_out_valid = (count_q != '0);
  assign pop            = data_out_valid && data_out_ready;

  always_comb begin
    c_man_d   = c_man_q;
    c_exp_d   = c_exp_q;
    c_valid_d = c_valid_q;
    if (accept) begin
      c_man_d   = man_cast;
      c_exp_d   = exp_cast;
      c_valid_d = 1'b1;
    end else if (push) begin
      c_valid_d = 1'b0;
    end
  end

  always_comb begin
    man_mem_d = man_mem_q;
    exp_mem_d = exp_mem_q;
    if (push) begin
      man_mem_d[wr_ptr_q] = c_man_q;
      exp_mem_d[wr_ptr_q] = c_exp_q;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_exp_q   <= '0;
      c_valid_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int b = 0; b < BLOCK_SIZE; b++) begin
        c_man_q[b] <= '0;
      end
      for (int d = 0; d < DEPTH; d++) begin
        exp_mem_q[d] <= '0;
        for (int b = 0; b < BLOCK_SIZE; b++) begin
          man_mem_q[d][b] <= '0;
        end
      end
    end else begin
      c_man_q   <= c_man_d;
      c_exp_q   <= c_exp_d;
      c_valid_q <= c_valid_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      man_mem_q <= man_mem_d;
      exp_mem_q <= exp_mem_d;
    end
  end

  assign mdata_out = man_mem_q[rd_ptr_q];
  assign edata_out = exp_mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: tb/tb_mxint_cast_fifo.sv
module tb_mxint_cast_fifo;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int fail_cnt = 0;

  // narrowing instance: 8->4 mantissa, 8->4 exponent, DEPTH 4
  logic signed [7:0] n_min [NB];
  logic signed [7:0] n_ein;
  logic              n_vin, n_rdy, n_ovld, n_ordy;
  logic signed [3:0] n_mout [NB];
  logic signed [3:0] n_eout;
  logic [2:0]        n_cnt;

  // widening instance: 4->8 mantissa, 8->4 exponent, DEPTH 4
  logic signed [3:0] w_min [NB];
  logic signed [7:0] w_ein;
  logic              w_vin, w_rdy, w_ovld, w_ordy;
  logic signed [7:0] w_mout [NB];
  logic signed [3:0] w_eout;
  logic [2:0]        w_cnt;

  // default-parameter instance: equal widths
  logic signed [7:0] e_min [NB];
  logic signed [7:0] e_ein;
  logic              e_vin, e_rdy, e_ovld, e_ordy;
  logic signed [7:0] e_mout [NB];
  logic signed [7:0] e_eout;
  logic [3:0]        e_cnt;

  mxint_cast_fifo #(.IN_MAN_WIDTH(8), .IN_EXP_WIDTH(8), .OUT_MAN_WIDTH(4),
                    .OUT_EXP_WIDTH(4), .BLOCK_SIZE(NB), .DEPTH(4)) dut_n (
    .clk(clk), .rst(rst), .mdata_in(n_min), .edata_in(n_ein),
    .data_in_valid(n_vin), .data_in_ready(n_rdy), .mdata_out(n_mout),
    .edata_out(n_eout), .data_out_valid(n_ovld), .data_out_ready(n_ordy),
    .count(n_cnt));

  mxint_cast_fifo #(.IN_MAN_WIDTH(4), .IN_EXP_WIDTH(8), .OUT_MAN_WIDTH(8),
                    .OUT_EXP_WIDTH(4), .BLOCK_SIZE(NB), .DEPTH(4)) dut_w (
    .clk(clk), .rst(rst), .mdata_in(w_min), .edata_in(w_ein),
    .data_in_valid(w_vin), .data_in_ready(w_rdy), .mdata_out(w_mout),
    .edata_out(w_eout), .data_out_valid(w_ovld), .data_out_ready(w_ordy),
    .count(w_cnt));

  mxint_cast_fifo dut_e (
    .clk(clk), .rst(rst), .mdata_in(e_min), .edata_in(e_ein),
    .data_in_valid(e_vin), .data_in_ready(e_rdy), .mdata_out(e_mout),
    .edata_out(e_eout), .data_out_valid(e_ovld), .data_out_ready(e_ordy),
    .count(e_cnt));

  task automatic set_n(input int m0, input int m1, input int m2, input int m3, input int e);
    n_min[0] = 8'(m0); n_min[1] = 8'(m1); n_min[2] = 8'(m2); n_min[3] = 8'(m3);
    n_ein = 8'(e);
  endtask

  task automatic set_w(input int m0, input int m1, input int m2, input int m3, input int e);
    w_min[0] = 4'(m0); w_min[1] = 4'(m1); w_min[2] = 4'(m2); w_min[3] = 4'(m3);
    w_ein = 8'(e);
  endtask

  task automatic set_e(input int m0, input int m1, input int m2, input int m3, input int e);
    e_min[0] = 8'(m0); e_min[1] = 8'(m1); e_min[2] = 8'(m2); e_min[3] = 8'(m3);
    e_ein = 8'(e);
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk_cnt++; if (n_ovld !== 1'b0) begin fail_cnt++; $display("FAIL reset_n_ovld: got %b want 0", n_ovld); end
    chk_cnt++; if (n_rdy !== 1'b1) begin fail_cnt++; $display("FAIL reset_n_rdy: got %b want 1", n_rdy); end
    chk_cnt++; if (n_cnt !== 3'd0) begin fail_cnt++; $display("FAIL reset_n_cnt: got %0d want 0", n_cnt); end
    chk_cnt++; if (n_eout !== 4'sd0) begin fail_cnt++; $display("FAIL reset_n_eout: got %0d want 0", n_eout); end
    chk_cnt++; if (n_mout[0] !== 4'sd0) begin fail_cnt++; $display("FAIL reset_n_mout0: got %0d want 0", n_mout[0]); end
    chk_cnt++; if (w_ovld !== 1'b0) begin fail_cnt++; $display("FAIL reset_w_ovld: got %b want 0", w_ovld); end
    chk_cnt++; if (e_rdy !== 1'b1) begin fail_cnt++; $display("FAIL reset_e_rdy: got %b want 1", e_rdy); end
    rst = 1'b1;
  endtask

  task automatic test_narrow();
    int exp_m[NB];
    exp_m = '{6, -7, 0, -1};
    @(negedge clk);
    set_n(100, -100, 7, -1, 3); n_vin = 1'b1; n_ordy = 1'b0;
    chk_cnt++; if (n_rdy !== 1'b1) begin fail_cnt++; $display("FAIL narrow_rdy: got %b want 1", n_rdy); end
    @(negedge clk);
    n_vin = 1'b0;
    chk_cnt++; if (n_ovld !== 1'b0) begin fail_cnt++; $display("FAIL narrow_lat1_ovld: got %b want 0", n_ovld); end
    @(negedge clk);
    chk_cnt++; if (n_ovld !== 1'b1) begin fail_cnt++; $display("FAIL narrow_lat2_ovld: got %b want 1", n_ovld); end
    chk_cnt++; if (n_cnt !== 3'd1) begin fail_cnt++; $display("FAIL narrow_cnt: got %0d want 1", n_cnt); end
    for (int i = 0; i < NB; i++) begin
      chk_cnt++; if (n_mout[i] !== exp_m[i]) begin fail_cnt++; $display("FAIL narrow_m%0d: got %0d want %0d", i, n_mout[i], exp_m[i]); end
    end
    chk_cnt++; if (n_eout !== 4'sd7) begin fail_cnt++; $display("FAIL narrow_e: got %0d want 7", n_eout); end
    n_ordy = 1'b1;
    @(negedge clk);
    n_ordy = 1'b0;
    chk_cnt++; if (n_ovld !== 1'b0) begin fail_cnt++; $display("FAIL narrow_pop_ovld: got %b want 0", n_ovld); end
    chk_cnt++; if (n_cnt !== 3'd0) begin fail_cnt++; $display("FAIL narrow_pop_cnt: got %0d want 0", n_cnt); end
  endtask

  task automatic test_widen();
    int exp_a[NB];
    int exp_b[NB];
    exp_a = '{48, -128, 0, 112};
    exp_b = '{16, -16, 32, -32};
    @(negedge clk);
    set_w(3, -8, 0, 7, 0); w_vin = 1'b1; w_ordy = 1'b0;
    @(negedge clk);
    set_w(1, -1, 2, -2, -9);
    @(negedge clk);
    w_vin = 1'b0;
    chk_cnt++; if (w_cnt !== 3'd1) begin fail_cnt++; $display("FAIL widen_cnt1: got %0d want 1", w_cnt); end
    @(negedge clk);
    chk_cnt++; if (w_cnt !== 3'd2) begin fail_cnt++; $display("FAIL widen_cnt2: got %0d want 2", w_cnt); end
    for (int i = 0; i < NB; i++) begin
      chk_cnt++; if (w_mout[i] !== exp_a[i]) begin fail_cnt++; $display("FAIL widen_a_m%0d: got %0d want %0d", i, w_mout[i], exp_a[i]); end
    end
    chk_cnt++; if (w_eout !== -4'sd4) begin fail_cnt++; $display("FAIL widen_a_e: got %0d want -4", w_eout); end
    w_ordy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      chk_cnt++; if (w_mout[i] !== exp_b[i]) begin fail_cnt++; $display("FAIL widen_b_m%0d: got %0d want %0d", i, w_mout[i], exp_b[i]); end
    end
    chk_cnt++; if (w_eout !== -4'sd8) begin fail_cnt++; $display("FAIL widen_b_e_sat: got %0d want -8", w_eout); end
    @(negedge clk);
    w_ordy = 1'b0;
    chk_cnt++; if (w_ovld !== 1'b0) begin fail_cnt++; $display("FAIL widen_drain_ovld: got %b want 0", w_ovld); end
  endtask

  task automatic test_sat();
    int exp_a[NB];
    int exp_b[NB];
    exp_a = '{1, -1, 0, 7};
    exp_b = '{-8, 7, -2, 0};
    @(negedge clk);
    set_n(16, -16, 0, 127, 6); n_vin = 1'b1; n_ordy = 1'b0;
    @(negedge clk);
    set_n(-128, 127, -17, 15, -128);
    @(negedge clk);
    n_vin = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      chk_cnt++; if (n_mout[i] !== exp_a[i]) begin fail_cnt++; $display("FAIL sat_a_m%0d: got %0d want %0d", i, n_mout[i], exp_a[i]); end
    end
    chk_cnt++; if (n_eout !== 4'sd7) begin fail_cnt++; $display("FAIL sat_a_e_hi: got %0d want 7", n_eout); end
    n_ordy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      chk_cnt++; if (n_mout[i] !== exp_b[i]) begin fail_cnt++; $display("FAIL sat_b_m%0d: got %0d want %0d", i, n_mout[i], exp_b[i]); end
    end
    chk_cnt++; if (n_eout !== -4'sd8) begin fail_cnt++; $display("FAIL sat_b_e_lo: got %0d want -8", n_eout); end
    @(negedge clk);
    n_ordy = 1'b0;
    chk_cnt++; if (n_cnt !== 3'd0) begin fail_cnt++; $display("FAIL sat_drain_cnt: got %0d want 0", n_cnt); end
  endtask

  task automatic test_equal();
    int exp_m[NB];
    exp_m = '{5, -5, 127, -128};
    @(negedge clk);
    set_e(5, -5, 127, -128, -3); e_vin = 1'b1; e_ordy = 1'b0;
    @(negedge clk);
    e_vin = 1'b0;
    chk_cnt++; if (e_ovld !== 1'b0) begin fail_cnt++; $display("FAIL equal_lat1_ovld: got %b want 0", e_ovld); end
    @(negedge clk);
    chk_cnt++; if (e_ovld !== 1'b1) begin fail_cnt++; $display("FAIL equal_lat2_ovld: got %b want 1", e_ovld); end
    for (int i = 0; i < NB; i++) begin
      chk_cnt++; if (e_mout[i] !== exp_m[i]) begin fail_cnt++; $display("FAIL equal_m%0d: got %0d want %0d", i, e_mout[i], exp_m[i]); end
    end
    chk_cnt++; if (e_eout !== -8'sd3) begin fail_cnt++; $display("FAIL equal_e: got %0d want -3", e_eout); end
    e_ordy = 1'b1;
    @(negedge clk);
    e_ordy = 1'b0;
    chk_cnt++; if (e_cnt !== 4'd0) begin fail_cnt++; $display("FAIL equal_pop_cnt: got %0d want 0", e_cnt); end
  endtask

  task automatic test_backpressure();
    int k;
    k = 0;
    n_ordy = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      set_n(16*k, -16*k-16, 32, -1, k-4);
      n_vin = 1'b1;
      if (n_rdy) k++;
    end
    @(negedge clk);
    n_vin = 1'b0;
    chk_cnt++; if (k !== 5) begin fail_cnt++; $display("FAIL bp_accepted: got %0d want 5", k); end
    chk_cnt++; if (n_cnt !== 3'd4) begin fail_cnt++; $display("FAIL bp_cnt_full: got %0d want 4", n_cnt); end
    chk_cnt++; if (n_rdy !== 1'b0) begin fail_cnt++; $display("FAIL bp_rdy_low: got %b want 0", n_rdy); end
    n_ordy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk_cnt++; if (n_ovld !== 1'b1) begin fail_cnt++; $display("FAIL bp_drain_ovld%0d: got %b want 1", j, n_ovld); end
      chk_cnt++; if (n_mout[0] !== j) begin fail_cnt++; $display("FAIL bp_drain_m0_%0d: got %0d want %0d", j, n_mout[0], j); end
      chk_cnt++; if (n_mout[1] !== -j-1) begin fail_cnt++; $display("FAIL bp_drain_m1_%0d: got %0d want %0d", j, n_mout[1], -j-1); end
      chk_cnt++; if (n_eout !== j) begin fail_cnt++; $display("FAIL bp_drain_e%0d: got %0d want %0d", j, n_eout, j); end
      @(negedge clk);
    end
    n_ordy = 1'b0;
    chk_cnt++; if (n_ovld !== 1'b0) begin fail_cnt++; $display("FAIL bp_empty_ovld: got %b want 0", n_ovld); end
    chk_cnt++; if (n_cnt !== 3'd0) begin fail_cnt++; $display("FAIL bp_empty_cnt: got %0d want 0", n_cnt); end
  endtask

  task automatic test_streaming();
    int k, r, first, last;
    k = 0; r = 0; first = -1; last = -1;
    n_ordy = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      chk_cnt++; if (n_cnt > 3'd1) begin fail_cnt++; $display("FAIL stream_cnt_c%0d: got %0d want <=1", cyc, n_cnt); end
      if (n_ovld) begin
        chk_cnt++; if (n_mout[0] !== (r % 8) - 4) begin fail_cnt++; $display("FAIL stream_m0_b%0d: got %0d want %0d", r, n_mout[0], (r % 8) - 4); end
        chk_cnt++; if (n_mout[1] !== -(r % 5)) begin fail_cnt++; $display("FAIL stream_m1_b%0d: got %0d want %0d", r, n_mout[1], -(r % 5)); end
        chk_cnt++; if (n_eout !== r % 8) begin fail_cnt++; $display("FAIL stream_e_b%0d: got %0d want %0d", r, n_eout, r % 8); end
        if (first < 0) first = cyc;
        last = cyc;
        r++;
      end
      if (k < 20) begin
        set_n(16*(k % 8) - 64, -16*(k % 5), 0, -1, (k % 8) - 4);
        n_vin = 1'b1;
        chk_cnt++; if (n_rdy !== 1'b1) begin fail_cnt++; $display("FAIL stream_rdy_b%0d: got %b want 1", k, n_rdy); end
        if (n_rdy) k++;
      end else begin
        n_vin = 1'b0;
      end
    end
    n_ordy = 1'b0;
    chk_cnt++; if (r !== 20) begin fail_cnt++; $display("FAIL stream_count: got %0d want 20", r); end
    chk_cnt++; if (first !== 2) begin fail_cnt++; $display("FAIL stream_first: got %0d want 2", first); end
    chk_cnt++; if (last !== 21) begin fail_cnt++; $display("FAIL stream_last: got %0d want 21", last); end
  endtask

  task automatic test_reset_mid();
    int exp_m[NB];
    exp_m = '{6, -7, 0, -1};
    n_ordy = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      set_n(16*b, -16, 0, -1, 0); n_vin = 1'b1;
    end
    @(negedge clk);
    n_vin = 1'b0;
    @(negedge clk);
    chk_cnt++; if (n_cnt !== 3'd3) begin fail_cnt++; $display("FAIL rmid_pre_cnt: got %0d want 3", n_cnt); end
    #2 rst = 1'b0;
    #1;
    chk_cnt++; if (n_ovld !== 1'b0) begin fail_cnt++; $display("FAIL rmid_ovld: got %b want 0", n_ovld); end
    chk_cnt++; if (n_rdy !== 1'b1) begin fail_cnt++; $display("FAIL rmid_rdy: got %b want 1", n_rdy); end
    chk_cnt++; if (n_cnt !== 3'd0) begin fail_cnt++; $display("FAIL rmid_cnt: got %0d want 0", n_cnt); end
    chk_cnt++; if (n_mout[0] !== 4'sd0) begin fail_cnt++; $display("FAIL rmid_mout0: got %0d want 0", n_mout[0]); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_n(100, -100, 7, -1, 3); n_vin = 1'b1;
    @(negedge clk);
    n_vin = 1'b0;
    chk_cnt++; if (n_ovld !== 1'b0) begin fail_cnt++; $display("FAIL rmid_lat1_ovld: got %b want 0", n_ovld); end
    @(negedge clk);
    chk_cnt++; if (n_ovld !== 1'b1) begin fail_cnt++; $display("FAIL rmid_lat2_ovld: got %b want 1", n_ovld); end
    chk_cnt++; if (n_cnt !== 3'd1) begin fail_cnt++; $display("FAIL rmid_post_cnt: got %0d want 1", n_cnt); end
    for (int i = 0; i < NB; i++) begin
      chk_cnt++; if (n_mout[i] !== exp_m[i]) begin fail_cnt++; $display("FAIL rmid_m%0d: got %0d want %0d", i, n_mout[i], exp_m[i]); end
    end
    chk_cnt++; if (n_eout !== 4'sd7) begin fail_cnt++; $display("FAIL rmid_e: got %0d want 7", n_eout); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    set_n(0, 0, 0, 0, 0); n_vin = 1'b0; n_ordy = 1'b0;
    set_w(0, 0, 0, 0, 0); w_vin = 1'b0; w_ordy = 1'b0;
    set_e(0, 0, 0, 0, 0); e_vin = 1'b0; e_ordy = 1'b0;
    test_reset();
    test_narrow();
    test_widen();
    test_sat();
    test_equal();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
